test_scope_cap: RTL
===================

TEST_SCOPE_CAP -- requirements
Module: io_test_scope

Interface
REQ-001 SHALL have parameter CAddrBase, default 16'h0000, IO base address.
REQ-002 SHALL have parameter CDepthLog2, default 8, log2 of sample buffer depth D (D=256 by default).
REQ-003 SHALL have port AClkH input 1, sole clock; all state on its rising edge.
REQ-004 SHALL have port AResetH input 1, asynchronous active-high reset.
REQ-005 SHALL have port AClkHEn input 1, clock enable; state, capture and IO side effects advance only when it is 1.
REQ-006 SHALL have ports AIoAddr in 16, AIoMosi in 64, AIoWrSize in 4, AIoRdSize in 4; nonzero size = access.
REQ-007 SHALL have ports AIoMiso out 64, AIoAddrAck out 1, AIoAddrErr out 1.
REQ-008 SHALL have port ATest16p input 16, sampled channel data from the 16-bit test multiplexer output.
REQ-009 SHALL have ports ATrigOut out 1 (trigger pulse) and ABusy out 1 (capture in progress).

Function
REQ-010 SHALL decode offsets 0 CTRL (write-only), 1 STAT (read-only), 2 DATA (read-only) relative to CAddrBase.
REQ-011 SHALL drive AIoAddrAck combinationally for any access to offsets 0..2; AIoAddrErr for write to 1/2 or read to 0; neither for other addresses.
REQ-012 SHALL drive AIoMiso to 0 except for acknowledged STAT/DATA reads; reads are combinational, same cycle.
REQ-013 CTRL write SHALL load mask=Mosi[15:0], value=Mosi[31:16], pretrig P=Mosi[32+CDepthLog2-1:32]; Mosi[48]=arm, Mosi[49]=abort.
REQ-014 SHALL implement states IDLE(0), PRE(1), WAIT(2), POST(3), DONE(4).
REQ-015 Arm SHALL from any state clear write pointer, read index, sample counter, done flag, and enter PRE (or WAIT if P=0); abort SHALL take priority over arm and enter IDLE.
REQ-016 In PRE, WAIT, POST SHALL write ATest16p to buffer[wptr] every enabled cycle, wptr incrementing modulo D.
REQ-017 PRE SHALL exit to WAIT after exactly P samples written.
REQ-018 Match SHALL be (ATest16p & mask) == (value & mask); mask=0 triggers on the first WAIT cycle.
REQ-019 On match in WAIT SHALL store trigger position T=wptr of the sample written that cycle, pulse ATrigOut for one enabled cycle, enter POST.
REQ-020 POST SHALL write D-1-P further samples, then enter DONE; total retained = D, buffer wrap overwrites oldest pre-trigger data.
REQ-021 P >= D SHALL be impossible by width; P=D-1 SHALL give zero POST samples (DONE next cycle).
REQ-022 STAT read SHALL return [2:0]=state, [3]=done, [4]=triggered, [31:16]=T zero-extended.
REQ-023 DATA read SHALL return [15:0]=buffer[(T-P+ridx) mod D], [31:16]=ridx; each DATA read in DONE SHALL increment ridx modulo D.
REQ-024 DATA reads outside DONE SHALL return 0 and not advance ridx.
REQ-025 ABusy SHALL be 1 in PRE, WAIT, POST.
REQ-026 CTRL write and DATA read in the same cycle cannot occur (single bus); arm arriving in POST SHALL abandon the capture.

Reset
REQ-027 On AResetH: state IDLE, mask/value/P/T/wptr/ridx 0, done 0, ATrigOut 0, ABusy 0; buffer contents undefined.
REQ-028 Reset mid-capture SHALL return to IDLE immediately, asynchronously, without further writes.

Configuration
REQ-029 Macro IO_TEST_SCOPE_EDGE_TRIG_EN defined: trigger SHALL require match this cycle AND no match on the previous WAIT sample (first WAIT cycle counts previous as match); undefined: level match per REQ-018.

Verification
REQ-030 Reset, then STAT read -> 0x0, ABusy=0, ATrigOut=0; read of offset 0 -> AIoAddrErr=1.
REQ-031 Ramp ATest16p=cycle count, CTRL mask=FFFF value=0x0100 P=16 arm -> trigger at sample 0x0100, DONE after 239 POST cycles; DATA reads 0..255 return 0x00F0..0x01EF, ridx 0..255.
REQ-032 mask=0, P=0 arm -> trigger first WAIT cycle, T=0, ATrigOut one cycle, DONE after 255 more samples.
REQ-033 Arm, then abort+arm same write during WAIT -> IDLE, ABusy=0, DATA reads return 0.
REQ-034 With EDGE_TRIG_EN, ATest16p held at value before arm -> no trigger until it leaves and returns; without it -> immediate trigger.
REQ-035 AClkHEn toggling 1/0 during ramp capture -> identical buffer contents as REQ-031 per enabled cycle; assert AResetH in POST -> STAT=0.

Source files
------------

// File: rtl/test_scope_cap.sv
// test_scope_cap: IO-mapped 16-channel capture scope with a pre-trigger window and a mask/value trigger.
// Define IO_TEST_SCOPE_EDGE_TRIG_EN to trigger on a new match instead of on a match level.
module test_scope_cap #(
   parameter logic [15:0] CAddrBase  = 16'h0000,
   parameter int unsigned CDepthLog2 = 8
) (
   input  logic        AClkH,
   input  logic        AResetH,
   input  logic        AClkHEn,
   input  logic [15:0] AIoAddr,
   input  logic [63:0] AIoMosi,
   input  logic [3:0]  AIoWrSize,
   input  logic [3:0]  AIoRdSize,
   output logic [63:0] AIoMiso,
   output logic        AIoAddrAck,
   output logic        AIoAddrErr,
   input  logic [15:0] ATest16p,
   output logic        ATrigOut,
   output logic        ABusy
);
   localparam int unsigned Depth = 1 << CDepthLog2;
   localparam logic [CDepthLog2-1:0] One = {{(CDepthLog2-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      WAIT = 3'd2,
      POST = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t state, state_nx;

   logic [15:0]           mask, value, offset;
   logic [CDepthLog2-1:0] pre_len, post_len, trig_pos, wptr, ridx, cnt, rd_addr, arm_len;
   logic                  done, triggered, trig_out;
   logic [15:0]           buffer [Depth];

   logic wr, rd, hit_ctrl, hit_stat, hit_data, ctrl_wr, arm, abort, data_rd;
   logic match, trigger, capture, trig_hit;
   logic unused_mosi;

   assign wr          = |AIoWrSize;
   assign rd          = |AIoRdSize;
   assign offset      = AIoAddr - CAddrBase;
   assign hit_ctrl    = (offset == 16'd0);
   assign hit_stat    = (offset == 16'd1);
   assign hit_data    = (offset == 16'd2);
   assign AIoAddrAck  = (wr | rd) & (hit_ctrl | hit_stat | hit_data);
   assign AIoAddrErr  = (wr & (hit_stat | hit_data)) | (rd & hit_ctrl);
   assign ctrl_wr     = wr & hit_ctrl;
   assign abort       = ctrl_wr & AIoMosi[49];
   assign arm         = ctrl_wr & AIoMosi[48] & ~AIoMosi[49];
   assign data_rd     = rd & hit_data & (state == DONE);
   assign arm_len     = AIoMosi[32 +: CDepthLog2];
   assign unused_mosi = ^AIoMosi[63:32];

   // D-1-P post-trigger samples, which is the bitwise complement of P.
   assign post_len = ~pre_len;
   assign rd_addr  = trig_pos - pre_len + ridx;
   assign match    = ((ATest16p ^ value) & mask) == 16'h0000;
   assign ABusy    = (state == PRE) || (state == WAIT) || (state == POST);
   assign ATrigOut = trig_out;

`ifdef IO_TEST_SCOPE_EDGE_TRIG_EN
   logic prev_match;

   // Outside WAIT (and on re-arm) the previous sample counts as matching.
   always_ff @(posedge AClkH or posedge AResetH) begin
      if (AResetH)
         prev_match <= 1'b1;
      else if (AClkHEn)
         prev_match <= (state == WAIT && !arm) ? match : 1'b1;
   end

   assign trigger = match & ~prev_match;
`else
   assign trigger = match;
`endif

   always_comb begin
      AIoMiso = '0;
      if (rd && hit_stat) begin
         AIoMiso[2:0]              = state;
         AIoMiso[3]                = done;
         AIoMiso[4]                = triggered;
         AIoMiso[16 +: CDepthLog2] = trig_pos;
      end else if (rd && hit_data && state == DONE) begin
         AIoMiso[15:0]             = buffer[rd_addr];
         AIoMiso[16 +: CDepthLog2] = ridx;
      end
   end

   always_comb begin
      state_nx = state;
      capture  = 1'b0;
      trig_hit = 1'b0;
      if (abort)
         state_nx = IDLE;
      else if (arm)
         state_nx = (arm_len == '0) ? WAIT : PRE;
      else begin
         case (state)
            PRE: begin
               capture = 1'b1;
               if (cnt == pre_len - One) state_nx = WAIT;
            end
            WAIT: begin
               capture = 1'b1;
               if (trigger) begin
                  trig_hit = 1'b1;
                  state_nx = (post_len == '0) ? DONE : POST;
               end
            end
            POST: begin
               capture = 1'b1;
               if (cnt == post_len - One) state_nx = DONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge AClkH or posedge AResetH) begin
      if (AResetH)
         state <= IDLE;
      else if (AClkHEn)
         state <= state_nx;
   end

   always_ff @(posedge AClkH or posedge AResetH) begin
      if (AResetH) begin
         mask      <= '0;
         value     <= '0;
         pre_len   <= '0;
         trig_pos  <= '0;
         wptr      <= '0;
         ridx      <= '0;
         cnt       <= '0;
         done      <= 1'b0;
         triggered <= 1'b0;
         trig_out  <= 1'b0;
      end else if (AClkHEn) begin
         trig_out <= trig_hit;
         if (ctrl_wr) begin
            mask    <= AIoMosi[15:0];
            value   <= AIoMosi[31:16];
            pre_len <= arm_len;
         end
         if (arm) begin
            wptr      <= '0;
            ridx      <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            triggered <= 1'b0;
         end else begin
            if (capture) wptr <= wptr + One;
            if (state_nx != state) cnt <= '0;
            else if (capture) cnt <= cnt + One;
            if (trig_hit) begin
               trig_pos  <= wptr;
               triggered <= 1'b1;
            end
            if (state_nx == DONE && state != DONE) done <= 1'b1;
            if (data_rd) ridx <= ridx + One;
         end
      end
   end

   always_ff @(posedge AClkH) begin
      if (AClkHEn && capture)
         buffer[wptr] <= ATest16p;
   end

endmodule
